bist_controller: RTL

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bist_controller.sv
// Logic-BIST sequencer: drives a scan chain and compacts its response into a 16-bit CRC signature.
// Optional macro BIST_ABORT_EN adds an abort input that cancels a run in progress.
module bist_controller #(
  parameter int          CHAIN_LEN    = 8,
  parameter int          NUM_PATTERNS = 16,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        scan_out,
`ifdef BIST_ABORT_EN
  input  logic        abort,
`endif
  output logic        mode,
  output logic        lfsr_clear,
  output logic        scan_enable,
  output logic [15:0] signature,
  output logic        bist_done,
  output logic        bist_pass
);

  localparam int SW = $clog2(CHAIN_LEN) + 1;
  localparam int PW = $clog2(NUM_PATTERNS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_cnt;
  logic [PW-1:0]   r_pat;
  logic [15:0]     r_sig;
  logic            r_mode;
  logic            r_clr;
  logic            r_se;
  logic            r_done;
  logic            r_pass;

  logic            w_abort;
  logic            w_cnt_last;
  logic [PW-1:0]   w_pat_inc;
  logic [15:0]     w_sig_step;

`ifdef BIST_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_cnt_last = (r_cnt == SW'(CHAIN_LEN - 1));
  assign w_pat_inc  = r_pat + PW'(1);

  // One step of the CRC-16/CCITT serial compactor
  assign w_sig_step = {r_sig[14:0], 1'b0} ^
                      ((r_sig[15] ^ scan_out) ? 16'h1021 : 16'h0000);

  // Sequencer: state, counters, signature and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_sig   <= '0;
      r_mode  <= 1'b0;
      r_clr   <= 1'b0;
      r_se    <= 1'b1;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (w_abort && r_state != S_IDLE) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_sig   <= '0;
      r_mode  <= 1'b0;
      r_clr   <= 1'b0;
      r_se    <= 1'b1;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_pat   <= '0;
            r_sig   <= '0;
            r_clr   <= 1'b1;
            r_mode  <= 1'b0;
            r_se    <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_INIT: begin
          r_state <= S_SHIFT;
          r_cnt   <= '0;
          r_clr   <= 1'b0;
          r_mode  <= 1'b1;
          r_se    <= 1'b1;
        end
        S_SHIFT: begin
          // First pattern's unload holds undefined chain data
          if (r_pat != '0) r_sig <= w_sig_step;
          if (w_cnt_last) begin
            r_state <= S_CAPTURE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_se    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end
        S_CAPTURE: begin
          r_pat <= w_pat_inc;
          r_se  <= 1'b1;
          if (w_pat_inc == PW'(NUM_PATTERNS)) begin
            r_state <= S_UNLOAD;
            r_mode  <= 1'b0;
          end else begin
            r_state <= S_SHIFT;
            r_mode  <= 1'b1;
          end
        end
        S_UNLOAD: begin
          r_sig <= w_sig_step;
          if (w_cnt_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_pass  <= (w_sig_step == GOLDEN_SIG);
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mode  <= 1'b0;
          r_clr   <= 1'b0;
          r_se    <= 1'b1;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign mode        = r_mode;
  assign lfsr_clear  = r_clr;
  assign scan_enable = r_se;
  assign signature   = r_sig;
  assign bist_done   = r_done;
  assign bist_pass   = r_pass;

endmodule
